// File: rtl/axil_led_blink_pkg.sv
// Shared constants for the AXI-Lite LED blinker: register map,
// CTRL bit positions and AXI response codes.
package axil_led_blink_pkg;

  // Word index = byte offset >> 2 (0x00, 0x04, ... 0x10)
  typedef enum logic [2:0] {
    REG_CTRL    = 3'd0,
    REG_HALF    = 3'd1,
    REG_MASK    = 3'd2,
    REG_STATUS  = 3'd3,
    REG_TOGGLES = 3'd4
  } reg_idx_e;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_INV = 1;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  function automatic logic [31:0] apply_strb(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_led_blink_core.sv
// Blink core: half-period counter, phase flop and registered LED drive.
// toggle pulses in the cycle whose closing edge flips the phase.
module led_blink_core #(
  parameter int N_LEDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              invert,
  input  logic [31:0]       half_period,
  input  logic [N_LEDS-1:0] mask,
  output logic [N_LEDS-1:0] led,
  output logic              phase,
  output logic              toggle
);

  logic [31:0] cnt_q;
  logic [31:0] limit;

  // A half-period of 0 is treated as 1
  assign limit  = (half_period == '0) ? '0 : half_period - 32'd1;
  assign toggle = enable && (cnt_q >= limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      phase <= 1'b0;
      led   <= '0;
    end else begin
      if (!enable) begin
        cnt_q <= '0;
        phase <= 1'b0;
      end else if (toggle) begin
        cnt_q <= '0;
        phase <= ~phase;
      end else begin
        cnt_q <= cnt_q + 32'd1;
      end
      led <= (phase ^ invert) ? mask : '0;
    end
  end

endmodule

// File: rtl/axil_led_blink.sv
// AXI-Lite register block driving a programmable LED blink pattern.
// Optional TOGGLES counter at 0x10 enabled by AXIL_LED_BLINK_TOGGLES_EN.
module axil_led_blink
  import axil_led_blink_pkg::*;
#(
  parameter int          N_LEDS          = 4,
  parameter int          ADDR_W          = 40,
  parameter int unsigned DEF_HALF_PERIOD = 50000000,
  parameter bit          DEF_ENABLE      = 1'b1
) (
  input  logic              pl_sys_clk,
  input  logic              axil_arst_n,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic [2:0]        s_axil_awprot,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic [2:0]        s_axil_arprot,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  output logic [N_LEDS-1:0] led
);

  logic              rdy_q;
  logic              aw_held;
  logic              w_held;
  logic [2:0]        aw_idx;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [1:0]        ctrl_q;
  logic [31:0]       half_q;
  logic [N_LEDS-1:0] mask_q;
  logic [31:0]       mask_ext;
  logic [31:0]       mask_new;
  logic [31:0]       rd_mux;
  logic [31:0]       toggles;
  logic              phase;
  logic              toggle;
  logic              aw_fire;
  logic              w_fire;
  logic              ar_fire;
  logic              commit;

  assign s_axil_awready = rdy_q && !aw_held && !s_axil_bvalid;
  assign s_axil_wready  = rdy_q && !w_held && !s_axil_bvalid;
  assign s_axil_arready = rdy_q && !s_axil_rvalid;
  assign s_axil_bresp   = RESP_OKAY;
  assign s_axil_rresp   = RESP_OKAY;

  assign aw_fire = s_axil_awvalid && s_axil_awready;
  assign w_fire  = s_axil_wvalid && s_axil_wready;
  assign ar_fire = s_axil_arvalid && s_axil_arready;
  assign commit  = aw_held && w_held && !s_axil_bvalid;

  always_comb begin
    mask_ext             = '0;
    mask_ext[N_LEDS-1:0] = mask_q;
  end

  assign mask_new = apply_strb(mask_ext, wdata_q, wstrb_q);

  always_ff @(posedge pl_sys_clk or negedge axil_arst_n) begin
    if (!axil_arst_n) begin
      rdy_q         <= 1'b0;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      s_axil_bvalid <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axil_awaddr[4:2];
      end
      if (w_fire) begin
        w_held  <= 1'b1;
        wdata_q <= s_axil_wdata;
        wstrb_q <= s_axil_wstrb;
      end
      if (commit) begin
        aw_held       <= 1'b0;
        w_held        <= 1'b0;
        s_axil_bvalid <= 1'b1;
      end else if (s_axil_bvalid && s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge pl_sys_clk or negedge axil_arst_n) begin
    if (!axil_arst_n) begin
      ctrl_q <= {1'b0, DEF_ENABLE};
      half_q <= 32'(DEF_HALF_PERIOD);
      mask_q <= '1;
    end else if (commit) begin
      case (aw_idx)
        REG_CTRL: if (wstrb_q[0]) ctrl_q <= wdata_q[1:0];
        REG_HALF: half_q <= apply_strb(half_q, wdata_q, wstrb_q);
        REG_MASK: mask_q <= mask_new[N_LEDS-1:0];
        default:  ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (s_axil_araddr[4:2])
      REG_CTRL:    rd_mux[1:0] = ctrl_q;
      REG_HALF:    rd_mux      = half_q;
      REG_MASK:    rd_mux      = mask_ext;
      REG_STATUS:  rd_mux[0]   = phase;
      REG_TOGGLES: rd_mux      = toggles;
      default:     ;
    endcase
  end

  always_ff @(posedge pl_sys_clk or negedge axil_arst_n) begin
    if (!axil_arst_n) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
    end else if (ar_fire) begin
      s_axil_rvalid <= 1'b1;
      s_axil_rdata  <= rd_mux;
    end else if (s_axil_rvalid && s_axil_rready) begin
      s_axil_rvalid <= 1'b0;
    end
  end

`ifdef AXIL_LED_BLINK_TOGGLES_EN
  logic [31:0] tog_q;

  // Clear wins over a coincident toggle
  always_ff @(posedge pl_sys_clk or negedge axil_arst_n) begin
    if (!axil_arst_n) begin
      tog_q <= '0;
    end else if (commit && aw_idx == REG_TOGGLES) begin
      tog_q <= '0;
    end else if (toggle) begin
      tog_q <= tog_q + 32'd1;
    end
  end

  assign toggles = tog_q;
`else
  logic unused_toggle;
  assign unused_toggle = toggle;
  assign toggles       = '0;
`endif

  led_blink_core #(
    .N_LEDS(N_LEDS)
  ) u_core (
    .clk        (pl_sys_clk),
    .rst_n      (axil_arst_n),
    .enable     (ctrl_q[CTRL_EN]),
    .invert     (ctrl_q[CTRL_INV]),
    .half_period(half_q),
    .mask       (mask_q),
    .led        (led),
    .phase      (phase),
    .toggle     (toggle)
  );

  logic unused_in;
  assign unused_in = ^{s_axil_awprot, s_axil_arprot,
                       s_axil_awaddr[ADDR_W-1:5], s_axil_awaddr[1:0],
                       s_axil_araddr[ADDR_W-1:5], s_axil_araddr[1:0],
                       mask_new};

endmodule
